// File: rtl/tiro_pkg.sv
// Shared definitions for the shot control units: opcodes, position-mux selects,
// FSM state encoding and sizing constants.
package tiro_pkg;

   localparam int N_SLOTS         = 16;
   localparam int COOLDOWN_CICLOS = 2;
   localparam int COOLDOWN_W      = $clog2(COOLDOWN_CICLOS + 1);

   localparam logic [1:0] OP_CIMA  = 2'b00;
   localparam logic [1:0] OP_DIR   = 2'b01;
   localparam logic [1:0] OP_BAIXO = 2'b10;
   localparam logic [1:0] OP_ESQ   = 2'b11;

   localparam logic [1:0] POS_NOVO = 2'b00;
   localparam logic [1:0] POS_X    = 2'b01;
   localparam logic [1:0] POS_Y    = 2'b10;

   typedef enum logic [3:0] {
      INICIAL   = 4'd0,
      ESPERA    = 4'd1,
      LER       = 4'd2,
      AVALIA    = 4'd3,
      MOVE      = 4'd4,
      GRAVA     = 4'd5,
      DESATIVA  = 4'd6,
      NOVO_TIRO = 4'd7,
      PROXIMO   = 4'd8,
      FIM_CICLO = 4'd9
   } estado_t;

endpackage

// File: rtl/uc_tiro_borda.sv
// Maps a travel direction plus the four border flags to "border reached in the
// direction of travel". Shared with the asteroid control unit.
module uc_tiro_borda
   import tiro_pkg::*;
(
   input  logic [1:0] opcode,
   input  logic       x_borda_min,
   input  logic       x_borda_max,
   input  logic       y_borda_min,
   input  logic       y_borda_max,
   output logic       atinge_borda
);

   always_comb begin
      atinge_borda = 1'b0;
      case (opcode)
         OP_CIMA:  atinge_borda = y_borda_min;
         OP_DIR:   atinge_borda = x_borda_max;
         OP_BAIXO: atinge_borda = y_borda_max;
         OP_ESQ:   atinge_borda = x_borda_min;
         default:  atinge_borda = 1'b0;
      endcase
   end

endmodule

// File: rtl/uc_tiro.sv
// Shot control unit: once per game tick sweeps every shot slot, moving, retiring
// or spawning shots. Optional spawn cooldown under DISPARO_COOLDOWN_EN.
//
// state     | meaning
// INICIAL   | clear slot counter, load memory and ship register
// ESPERA    | idle until iniciar_ciclo
// LER       | slot address settled, waiting for registered read data
// AVALIA    | decide spawn / skip / retire / move for the current slot
// MOVE      | adder computes the next coordinate
// GRAVA     | write moved position back to memory
// DESATIVA  | clear the loaded flag of the current slot
// NOVO_TIRO | write a new shot at ship position into the current slot
// PROXIMO   | advance slot counter or finish the sweep
// FIM_CICLO | pulse ciclo_pronto, rewind slot counter
module uc_tiro
   import tiro_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       iniciar_ciclo,
   input  logic       disparo,
   input  logic [1:0] opcode_disparo,
   input  logic       loaded_tiro,
   input  logic       colisao_tiro_asteroide,
   input  logic       rco_contador_tiro,
   input  logic       x_borda_min_tiro,
   input  logic       x_borda_max_tiro,
   input  logic       y_borda_min_tiro,
   input  logic       y_borda_max_tiro,
   input  logic [1:0] opcode_tiro,
   output logic       conta_contador_tiro,
   output logic       reset_contador_tiro,
   output logic [1:0] select_mux_pos_tiro,
   output logic       select_mux_coor_tiro,
   output logic       select_soma_sub_tiro,
   output logic       enable_mem_tiro,
   output logic       enable_load_tiro,
   output logic       new_load_tiro,
   output logic       reset_memoria_load,
   output logic       enable_reg_nave,
   output logic       reset_reg_nave,
   output logic [1:0] opcode_registra_tiro,
   output logic       ciclo_pronto,
   output logic       colisao_detectada,
   output logic [3:0] db_estado
);

   estado_t    estado, prox_estado;
   logic       disparo_pendente;
   logic [1:0] opcode_reg;
   logic       atinge_borda;
   logic       pode_disparar;
   logic       coor_mov;
   logic       sub_mov;

   uc_tiro_borda u_borda (
      .opcode       (opcode_tiro),
      .x_borda_min  (x_borda_min_tiro),
      .x_borda_max  (x_borda_max_tiro),
      .y_borda_min  (y_borda_min_tiro),
      .y_borda_max  (y_borda_max_tiro),
      .atinge_borda (atinge_borda)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado <= INICIAL;
      end else begin
         estado <= prox_estado;
      end
   end

   // The spawn clear takes priority: a request arriving during NOVO_TIRO is dropped,
   // but its opcode is still captured.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         disparo_pendente <= 1'b0;
         opcode_reg       <= OP_CIMA;
      end else begin
         if (estado == NOVO_TIRO) begin
            disparo_pendente <= 1'b0;
         end else if (disparo) begin
            disparo_pendente <= 1'b1;
         end
         if (disparo) begin
            opcode_reg <= opcode_disparo;
         end
      end
   end

`ifdef DISPARO_COOLDOWN_EN
   logic [COOLDOWN_W-1:0] cooldown;

   // Counts down once per completed sweep, so a spawn blocks the following sweeps.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cooldown <= '0;
      end else if (estado == NOVO_TIRO) begin
         cooldown <= COOLDOWN_W'(COOLDOWN_CICLOS);
      end else if ((estado == FIM_CICLO) && (cooldown != '0)) begin
         cooldown <= cooldown - COOLDOWN_W'(1);
      end
   end

   assign pode_disparar = (cooldown == '0);
`else
   assign pode_disparar = 1'b1;
`endif

   // Odd opcodes travel along x; up and left decrement the coordinate.
   assign coor_mov = ~opcode_tiro[0];
   assign sub_mov  = (opcode_tiro == OP_CIMA) || (opcode_tiro == OP_ESQ);

   always_comb begin
      prox_estado          = estado;
      conta_contador_tiro  = 1'b0;
      reset_contador_tiro  = 1'b0;
      select_mux_pos_tiro  = POS_NOVO;
      select_mux_coor_tiro = 1'b0;
      select_soma_sub_tiro = 1'b0;
      enable_mem_tiro      = 1'b0;
      enable_load_tiro     = 1'b0;
      new_load_tiro        = 1'b0;
      reset_memoria_load   = 1'b0;
      enable_reg_nave      = 1'b0;
      reset_reg_nave       = 1'b0;
      ciclo_pronto         = 1'b0;
      colisao_detectada    = 1'b0;

      case (estado)
         INICIAL: begin
            reset_contador_tiro = 1'b1;
            reset_memoria_load  = 1'b1;
            reset_reg_nave      = 1'b1;
            prox_estado         = ESPERA;
         end
         ESPERA: begin
            if (iniciar_ciclo) begin
               prox_estado = LER;
            end
         end
         LER: begin
            prox_estado = AVALIA;
         end
         AVALIA: begin
            if (!loaded_tiro && disparo_pendente && pode_disparar) begin
               prox_estado = NOVO_TIRO;
            end else if (!loaded_tiro) begin
               prox_estado = PROXIMO;
            end else if (colisao_tiro_asteroide) begin
               colisao_detectada = 1'b1;
               prox_estado       = DESATIVA;
            end else if (atinge_borda) begin
               prox_estado = DESATIVA;
            end else begin
               prox_estado = MOVE;
            end
         end
         MOVE: begin
            select_mux_coor_tiro = coor_mov;
            select_soma_sub_tiro = sub_mov;
            prox_estado          = GRAVA;
         end
         GRAVA: begin
            select_mux_coor_tiro = coor_mov;
            select_soma_sub_tiro = sub_mov;
            select_mux_pos_tiro  = opcode_tiro[0] ? POS_X : POS_Y;
            enable_mem_tiro      = 1'b1;
            prox_estado          = PROXIMO;
         end
         DESATIVA: begin
            enable_load_tiro = 1'b1;
            prox_estado      = PROXIMO;
         end
         NOVO_TIRO: begin
            select_mux_pos_tiro = POS_NOVO;
            enable_mem_tiro     = 1'b1;
            enable_load_tiro    = 1'b1;
            new_load_tiro       = 1'b1;
            enable_reg_nave     = 1'b1;
            prox_estado         = PROXIMO;
         end
         PROXIMO: begin
            if (rco_contador_tiro) begin
               prox_estado = FIM_CICLO;
            end else begin
               conta_contador_tiro = 1'b1;
               prox_estado         = LER;
            end
         end
         FIM_CICLO: begin
            ciclo_pronto        = 1'b1;
            reset_contador_tiro = 1'b1;
            prox_estado         = ESPERA;
         end
         default: begin
            prox_estado = INICIAL;
         end
      endcase
   end

   assign opcode_registra_tiro = opcode_reg;
   assign db_estado            = estado;

endmodule

// File: tb/tb_uc_tiro.sv
// Bench for uc_tiro: a small shot-datapath model plus a per-slot event scoreboard
// predicted from an independent model of slot occupancy and the fire request.
module tb_uc_tiro;

`ifdef DISPARO_COOLDOWN_EN
   localparam int COOL = 2;
`else
   localparam int COOL = 0;
`endif

   localparam logic [15:0] RST_OUTS = 16'h4050;
   localparam logic [2:0] EV_COL = 3'd1, EV_RET = 3'd2, EV_MOVE = 3'd3, EV_SPAWN = 3'd4, EV_BAD = 3'd7;
   localparam logic [3:0] BXMIN = 4'b1000, BXMAX = 4'b0100, BYMIN = 4'b0010, BYMAX = 4'b0001;

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] slot;
      logic [1:0] pos;
      logic       coor;
      logic       sub;
      logic [1:0] op;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       iniciar_ciclo = 1'b0;
   logic       disparo = 1'b0;
   logic [1:0] opcode_disparo = 2'b00;
   logic       loaded_tiro, colisao_tiro_asteroide, rco_contador_tiro;
   logic       x_borda_min_tiro, x_borda_max_tiro, y_borda_min_tiro, y_borda_max_tiro;
   logic [1:0] opcode_tiro;
   logic       conta_contador_tiro, reset_contador_tiro;
   logic [1:0] select_mux_pos_tiro;
   logic       select_mux_coor_tiro, select_soma_sub_tiro;
   logic       enable_mem_tiro, enable_load_tiro, new_load_tiro, reset_memoria_load;
   logic       enable_reg_nave, reset_reg_nave;
   logic [1:0] opcode_registra_tiro;
   logic       ciclo_pronto, colisao_detectada;
   logic [3:0] db_estado;
   logic [15:0] outs;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   uc_tiro dut (
      .clock                  (clock),
      .reset_n                (reset_n),
      .iniciar_ciclo          (iniciar_ciclo),
      .disparo                (disparo),
      .opcode_disparo         (opcode_disparo),
      .loaded_tiro            (loaded_tiro),
      .colisao_tiro_asteroide (colisao_tiro_asteroide),
      .rco_contador_tiro      (rco_contador_tiro),
      .x_borda_min_tiro       (x_borda_min_tiro),
      .x_borda_max_tiro       (x_borda_max_tiro),
      .y_borda_min_tiro       (y_borda_min_tiro),
      .y_borda_max_tiro       (y_borda_max_tiro),
      .opcode_tiro            (opcode_tiro),
      .conta_contador_tiro    (conta_contador_tiro),
      .reset_contador_tiro    (reset_contador_tiro),
      .select_mux_pos_tiro    (select_mux_pos_tiro),
      .select_mux_coor_tiro   (select_mux_coor_tiro),
      .select_soma_sub_tiro   (select_soma_sub_tiro),
      .enable_mem_tiro        (enable_mem_tiro),
      .enable_load_tiro       (enable_load_tiro),
      .new_load_tiro          (new_load_tiro),
      .reset_memoria_load     (reset_memoria_load),
      .enable_reg_nave        (enable_reg_nave),
      .reset_reg_nave         (reset_reg_nave),
      .opcode_registra_tiro   (opcode_registra_tiro),
      .ciclo_pronto           (ciclo_pronto),
      .colisao_detectada      (colisao_detectada),
      .db_estado              (db_estado)
   );

   assign outs = {conta_contador_tiro, reset_contador_tiro, select_mux_pos_tiro,
                  select_mux_coor_tiro, select_soma_sub_tiro, enable_mem_tiro,
                  enable_load_tiro, new_load_tiro, reset_memoria_load, enable_reg_nave,
                  reset_reg_nave, opcode_registra_tiro, ciclo_pronto, colisao_detectada};

   // Datapath model: slot counter, loaded/opcode memory with registered read.
   bit         dp_loaded [16];
   bit [1:0]   dp_op [16];
   logic [3:0] dp_cnt = 4'd0;
   bit         q_loaded;
   bit [1:0]   q_op;
   bit [3:0]   brd [16];
   bit         col [16];

   always @(posedge clock) begin
      q_loaded <= dp_loaded[dp_cnt];
      q_op     <= dp_op[dp_cnt];
      if (reset_contador_tiro) dp_cnt <= 4'd0;
      else if (conta_contador_tiro) dp_cnt <= dp_cnt + 4'd1;
      if (reset_memoria_load) begin
         for (int i = 0; i < 16; i++) dp_loaded[i] <= 1'b0;
      end else if (enable_load_tiro) begin
         dp_loaded[dp_cnt] <= new_load_tiro;
      end
      if (enable_mem_tiro && select_mux_pos_tiro == 2'b00) dp_op[dp_cnt] <= opcode_registra_tiro;
   end

   assign loaded_tiro            = q_loaded;
   assign opcode_tiro            = q_op;
   assign rco_contador_tiro      = (dp_cnt == 4'd15);
   assign colisao_tiro_asteroide = col[dp_cnt];
   assign {x_borda_min_tiro, x_borda_max_tiro, y_borda_min_tiro, y_borda_max_tiro} = brd[dp_cnt];

   // Reference model of slot occupancy and the pending fire request.
   bit       m_loaded [16];
   bit [1:0] m_op [16];
   bit       m_pend = 1'b0;
   bit [1:0] m_pop = 2'b00;
   int       m_cool = 0;
   ev_t      exp_q[$];

   function automatic ev_t mk_ev(logic [2:0] k, logic [3:0] s, logic [1:0] p,
                                 logic c, logic sb, logic [1:0] o);
      ev_t e;
      e.kind = k; e.slot = s; e.pos = p; e.coor = c; e.sub = sb; e.op = o;
      return e;
   endfunction

   function automatic bit hits(bit [1:0] op, bit [3:0] b);
      case (op)
         2'd0: return b[1];
         2'd1: return b[2];
         2'd2: return b[0];
         default: return b[3];
      endcase
   endfunction

   function automatic bit [3:0] dir_border(bit [1:0] op);
      case (op)
         2'd0: return BYMIN;
         2'd1: return BXMAX;
         2'd2: return BYMAX;
         default: return BXMIN;
      endcase
   endfunction

   task automatic predict(output int lat);
      lat = 2;
      for (int i = 0; i < 16; i++) begin
         if (!m_loaded[i]) begin
            if (m_pend && m_cool == 0) begin
               exp_q.push_back(mk_ev(EV_SPAWN, i[3:0], 2'b00, 1'b0, 1'b0, m_pop));
               m_loaded[i] = 1'b1;
               m_op[i] = m_pop;
               m_pend = 1'b0;
               m_cool = COOL;
               lat += 4;
            end else begin
               lat += 3;
            end
         end else if (col[i]) begin
            exp_q.push_back(mk_ev(EV_COL, i[3:0], 2'b00, 1'b0, 1'b0, 2'b00));
            exp_q.push_back(mk_ev(EV_RET, i[3:0], 2'b00, 1'b0, 1'b0, 2'b00));
            m_loaded[i] = 1'b0;
            lat += 4;
         end else if (hits(m_op[i], brd[i])) begin
            exp_q.push_back(mk_ev(EV_RET, i[3:0], 2'b00, 1'b0, 1'b0, 2'b00));
            m_loaded[i] = 1'b0;
            lat += 4;
         end else begin
            exp_q.push_back(mk_ev(EV_MOVE, i[3:0], m_op[i][0] ? 2'b01 : 2'b10, ~m_op[i][0],
                                  (m_op[i] == 2'd0) || (m_op[i] == 2'd3), 2'b00));
            lat += 5;
         end
      end
      if (m_cool > 0) m_cool--;
   endtask

   task automatic fire(input logic [1:0] op);
      @(negedge clock);
      disparo = 1'b1;
      opcode_disparo = op;
      @(negedge clock);
      disparo = 1'b0;
      m_pend = 1'b1;
      m_pop = op;
   endtask

   // One sweep: predicted events are popped as the DUT produces them.
   task automatic do_sweep(input bit fire_on_spawn, input bit tick_mid);
      int  exp_lat, cyc;
      bit  done, have, fired;
      ev_t o, e;
      predict(exp_lat);
      fired = 1'b0;
      done = 1'b0;
      @(negedge clock);
      iniciar_ciclo = 1'b1;
      cyc = 1;
      while (!done && cyc < 400) begin
         @(negedge clock);
         iniciar_ciclo = 1'b0;
         disparo = 1'b0;
         cyc++;
         if (tick_mid && cyc == 10) iniciar_ciclo = 1'b1;
         have = 1'b0;
         o = mk_ev(EV_BAD, dp_cnt, 2'b00, 1'b0, 1'b0, 2'b00);
         if (colisao_detectada) begin
            have = 1'b1;
            o = mk_ev(EV_COL, dp_cnt, 2'b00, 1'b0, 1'b0, 2'b00);
         end else if (enable_mem_tiro || enable_load_tiro || enable_reg_nave) begin
            have = 1'b1;
            if (enable_mem_tiro && enable_load_tiro && new_load_tiro && enable_reg_nave
                && select_mux_pos_tiro == 2'b00)
               o = mk_ev(EV_SPAWN, dp_cnt, 2'b00, 1'b0, 1'b0, opcode_registra_tiro);
            else if (enable_mem_tiro && !enable_load_tiro && !enable_reg_nave
                     && (select_mux_pos_tiro == 2'b01 || select_mux_pos_tiro == 2'b10))
               o = mk_ev(EV_MOVE, dp_cnt, select_mux_pos_tiro, select_mux_coor_tiro,
                         select_soma_sub_tiro, 2'b00);
            else if (enable_load_tiro && !new_load_tiro && !enable_mem_tiro && !enable_reg_nave)
               o = mk_ev(EV_RET, dp_cnt, 2'b00, 1'b0, 1'b0, 2'b00);
            else
               o = mk_ev(EV_BAD, dp_cnt, select_mux_pos_tiro, select_mux_coor_tiro,
                         select_soma_sub_tiro, 2'b00);
         end
         if (have) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_event got=%h expected none", o);
            end else begin
               e = exp_q.pop_front();
               if (o !== e) begin
                  bad++;
                  $display("FAIL slot_event got=%h expected=%h", o, e);
               end
            end
            if (fire_on_spawn && o.kind == EV_SPAWN) begin
               disparo = 1'b1;
               opcode_disparo = 2'b10;
               fired = 1'b1;
            end
         end
         if (ciclo_pronto) done = 1'b1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL sweep_timeout got=%0d cycles without ciclo_pronto expected=%0d", cyc, exp_lat);
      end
      total++;
      if (cyc !== exp_lat) begin
         bad++;
         $display("FAIL sweep_latency got=%0d expected=%0d", cyc, exp_lat);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_events got=0 expected=%0d more", exp_q.size());
      end
      exp_q.delete();
      if (fired) begin
         m_pend = 1'b0;
         m_pop = 2'b10;
      end
      @(negedge clock);
      disparo = 1'b0;
      iniciar_ciclo = 1'b0;
      total++;
      if ({ciclo_pronto, db_estado} !== {1'b0, 4'd1}) begin
         bad++;
         $display("FAIL after_sweep got=%b/%0d expected=0/1", ciclo_pronto, db_estado);
      end
      @(negedge clock);
      total++;
      if (db_estado !== 4'd1) begin
         bad++;
         $display("FAIL idle_after_sweep got=%0d expected=1", db_estado);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      total++;
      if (outs !== RST_OUTS) begin
         bad++;
         $display("FAIL reset_outputs got=%h expected=%h", outs, RST_OUTS);
      end
      total++;
      if (db_estado !== 4'd0) begin
         bad++;
         $display("FAIL reset_state got=%0d expected=0", db_estado);
      end
      reset_n = 1'b1;
      @(negedge clock);
      total++;
      if (db_estado !== 4'd1) begin
         bad++;
         $display("FAIL state_after_reset got=%0d expected=1", db_estado);
      end
   endtask

   task automatic test_empty_sweep();
      do_sweep(1'b0, 1'b1);
   endtask

   task automatic test_spawn_move();
      fire(2'b01);
      do_sweep(1'b0, 1'b0);
      do_sweep(1'b0, 1'b0);
   endtask

   task automatic test_border();
      fire(2'b00);
      do_sweep(1'b0, 1'b0);
      brd[0] = BYMIN;
      brd[1] = BYMIN;
      do_sweep(1'b0, 1'b0);
      brd[0] = 4'b0000;
      brd[1] = 4'b0000;
   endtask

   task automatic test_collision();
      fire(2'b10);
      do_sweep(1'b0, 1'b0);
      col[1] = 1'b1;
      brd[1] = BYMAX;
      do_sweep(1'b0, 1'b0);
      col[1] = 1'b0;
      brd[1] = 4'b0000;
   endtask

   task automatic test_latch();
      fire(2'b01);
      fire(2'b11);
      do_sweep(1'b1, 1'b0);
      total++;
      if (opcode_registra_tiro !== m_pop) begin
         bad++;
         $display("FAIL opcode_latch got=%b expected=%b", opcode_registra_tiro, m_pop);
      end
      do_sweep(1'b0, 1'b0);
   endtask

   task automatic test_full();
      int n;
      for (int g = 0; g < 80; g++) begin
         n = 0;
         for (int i = 0; i < 16; i++) n += int'(m_loaded[i]);
         if (n == 16) break;
         if (!m_pend) fire(2'($urandom_range(3, 0)));
         do_sweep(1'b0, 1'b0);
      end
      fire(2'b11);
      do_sweep(1'b0, 1'b0);
      brd[7] = dir_border(m_op[7]);
      do_sweep(1'b0, 1'b0);
      brd[7] = 4'b0000;
      for (int g = 0; g < 3 && m_pend; g++) do_sweep(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      @(negedge clock);
      iniciar_ciclo = 1'b1;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clock);
         iniciar_ciclo = 1'b0;
         if (db_estado == 4'd5 && dp_cnt == 4'd5) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL reach_grava_slot5 got=state %0d slot %0d expected=state 5 slot 5", db_estado, dp_cnt);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (outs !== RST_OUTS) begin
         bad++;
         $display("FAIL async_reset_outputs got=%h expected=%h", outs, RST_OUTS);
      end
      total++;
      if (db_estado !== 4'd0) begin
         bad++;
         $display("FAIL async_reset_state got=%0d expected=0", db_estado);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) m_loaded[i] = 1'b0;
      m_pend = 1'b0;
      m_pop = 2'b00;
      m_cool = 0;
      @(negedge clock);
      do_sweep(1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_empty_sweep();
      test_spawn_move();
      test_border();
      test_collision();
      test_latch();
      test_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=still running expected=finished");
      $fatal(1);
   end

endmodule
